dunc16_timing: RTL and testbench
================================

DUNC16_TIMING -- requirements
Module: dunc16_timing

Interface
REQ-001 CLK  input  1  system clock; all state changes on rising edge.
REQ-002 RESET  input  1  reset, asynchronous, active-low.
REQ-003 RUN  input  1  level; rising edge arms free-running mode, low disarms it.
REQ-004 STEP  input  1  one-clock pulse; requests exactly one instruction (fetch plus execute).
REQ-005 HALT_REQ  input  1  from decoder; valid during EXECUTE, requests stop after the current instruction.
REQ-006 SHORT_EXEC  input  1  from decoder; sampled only at EXECUTE T1, ends the execute phase after T1.
REQ-007 FETCH  output  1  fetch phase active.
REQ-008 EXECUTE  output  1  execute phase active.
REQ-009 T0, T1, T2, T3  output  1 each  one-hot timing strobes within a phase.
REQ-010 INSTR_DONE  output  1  one-clock pulse in the cycle after the last strobe of an execute phase.
REQ-011 HALTED  output  1  sticky; sequencer stopped by HALT_REQ.
REQ-012 ICOUNT  output  16  completed-instruction count.

Function
REQ-013 States SHALL be IDLE, F0, F1, F2, F3, E0, E1, E2, E3; one registered state, outputs decoded from registered state only.
REQ-014 IDLE: FETCH=0, EXECUTE=0, all T low; Fn: FETCH=1, Tn=1; En: EXECUTE=1, Tn=1; never both FETCH and EXECUTE high.
REQ-015 Internal run flag SHALL set on a registered RUN rising edge, clear when RUN=0 or when a halt is taken.
REQ-016 IDLE -> F0 when run flag set or step pending; otherwise stay in IDLE.
REQ-017 F0->F1->F2->F3->E0->E1 unconditionally, one clock each.
REQ-018 E1: SHORT_EXEC=1 -> instruction end; else E1->E2->E3, with E3 the instruction end.
REQ-019 Instruction end: HALT_REQ seen at any E-state -> IDLE, HALTED=1, run flag cleared; else if step pending -> IDLE, step pending cleared; else if run flag -> F0; else IDLE.
REQ-020 STEP pulse SHALL set step pending only when in IDLE; pulses outside IDLE are ignored.
REQ-021 STEP in IDLE with run flag set: step pending is still recorded and stops the sequencer after one instruction.
REQ-022 HALTED SHALL clear when leaving IDLE; a RUN level held high after a halt SHALL NOT restart without a new rising edge.
REQ-023 HALT_REQ latch SHALL be cleared at every instruction end; HALT_REQ outside E-states is ignored.
REQ-024 ICOUNT SHALL increment by 1 on every instruction end and wrap 0xFFFF -> 0x0000; INSTR_DONE pulses in the same cycle.
REQ-025 RUN falling mid-instruction SHALL complete the current instruction, then enter IDLE.
REQ-026 Full instruction = 8 clocks; short instruction = 6 clocks; back-to-back instructions have no IDLE gap.

Reset
REQ-027 RESET low SHALL force IDLE, outputs FETCH/EXECUTE/T0-T3/INSTR_DONE/HALTED = 0, ICOUNT = 0x0000, run flag, step pending, halt latch and RUN edge register = 0.
REQ-028 RESET low mid-instruction SHALL abort immediately without incrementing ICOUNT; the first state after release is IDLE.

Structure
REQ-029 Shared package dunc16_pkg SHALL hold the state encoding typedef and the constant ICOUNT width (16).
REQ-030 One sub-module, dunc16_rise_detect, SHALL provide the registered RUN rising-edge pulse.

Verification
REQ-031 Reset, STEP pulse once -> F0,F1,F2,F3,E0,E1,E2,E3 one clock each, then IDLE; ICOUNT=1, one INSTR_DONE.
REQ-032 RUN rise, held high 4 instructions, then low -> 32 consecutive strobe clocks, ICOUNT=4, IDLE after E3 of the 4th.
REQ-033 RUN high, SHORT_EXEC=1 at E1 of the 2nd instruction -> that instruction takes 6 clocks, next F0 immediately follows E1.
REQ-034 RUN high, HALT_REQ at E2 -> IDLE after E3, HALTED=1, no restart while RUN stays high; new RUN rise -> F0, HALTED=0.
REQ-035 Preload ICOUNT to 0xFFFF via 65535 short steps (or force), one more instruction -> ICOUNT=0x0000.
REQ-036 RESET low during F2 of a run -> outputs 0 at once, ICOUNT unchanged; after release stays IDLE until RUN rise.

Source files
------------

// File: rtl/dunc16_pkg.sv
// Shared types and constants for the dunc16 timing sequencer.
package dunc16_pkg;
    localparam int ICOUNT_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_F0, ST_F1, ST_F2, ST_F3,
        ST_E0, ST_E1, ST_E2, ST_E3
    } state_t;
endpackage

// File: rtl/dunc16_timing_if.sv
// Control inputs and timing-strobe outputs of the dunc16 sequencer.
interface dunc16_timing_if;
    import dunc16_pkg::*;

    logic                RUN;
    logic                STEP;
    logic                HALT_REQ;
    logic                SHORT_EXEC;
    logic                FETCH;
    logic                EXECUTE;
    logic                T0, T1, T2, T3;
    logic                INSTR_DONE;
    logic                HALTED;
    logic [ICOUNT_W-1:0] ICOUNT;

    modport master (
        output RUN, STEP, HALT_REQ, SHORT_EXEC,
        input  FETCH, EXECUTE, T0, T1, T2, T3, INSTR_DONE, HALTED, ICOUNT
    );

    modport slave (
        input  RUN, STEP, HALT_REQ, SHORT_EXEC,
        output FETCH, EXECUTE, T0, T1, T2, T3, INSTR_DONE, HALTED, ICOUNT
    );
endinterface

// File: rtl/dunc16_rise_detect.sv
// Registered rising-edge detector: din is sampled twice so the pulse depends
// only on flops, never on the raw asynchronous level.
module dunc16_rise_detect (
    input  logic CLK,
    input  logic RESET,
    input  logic din,
    output logic rise
);
    logic [1:0] sh;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) sh <= '0;
        else        sh <= {sh[0], din};
    end

    assign rise = sh[0] & ~sh[1];
endmodule

// File: rtl/dunc16_timing.sv
// dunc16 instruction timing sequencer: fetch F0-F3, execute E0-E3 (or E0-E1
// when short), with run / single-step / halt control and an instruction counter.
module dunc16_timing
    import dunc16_pkg::*;
(
    input  logic           CLK,
    input  logic           RESET,
    dunc16_timing_if.slave bus
);
    state_t              state;
    logic                run_flag, step_pend, halt_lat;
    logic                instr_done, halted;
    logic [ICOUNT_W-1:0] icount;
    logic                run_rise, run_now, is_exec, instr_end, halt_now;
    logic                fetch, exec;
    logic [3:0]          t;

    dunc16_rise_detect u_rise (
        .CLK  (CLK),
        .RESET(RESET),
        .din  (bus.RUN),
        .rise (run_rise)
    );

    // A RUN drop in the final cycle must still stop the sequencer, so gate the flag.
    assign run_now   = run_flag & bus.RUN;
    assign is_exec   = state inside {ST_E0, ST_E1, ST_E2, ST_E3};
    assign instr_end = (state == ST_E3) || (state == ST_E1 && bus.SHORT_EXEC);
    assign halt_now  = halt_lat | bus.HALT_REQ;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_IDLE;
            run_flag   <= 1'b0;
            step_pend  <= 1'b0;
            halt_lat   <= 1'b0;
            instr_done <= 1'b0;
            halted     <= 1'b0;
            icount     <= '0;
        end else begin
            instr_done <= instr_end;
            if (run_rise)                     run_flag  <= 1'b1;
            if (!bus.RUN)                     run_flag  <= 1'b0;
            if (is_exec && bus.HALT_REQ)      halt_lat  <= 1'b1;
            if (state == ST_IDLE && bus.STEP) step_pend <= 1'b1;

            case (state)
                ST_IDLE: if (run_now || step_pend) begin
                    state  <= ST_F0;
                    halted <= 1'b0;
                end
                ST_F0:   state <= ST_F1;
                ST_F1:   state <= ST_F2;
                ST_F2:   state <= ST_F3;
                ST_F3:   state <= ST_E0;
                ST_E0:   state <= ST_E1;
                ST_E1:   state <= ST_E2;
                ST_E2:   state <= ST_E3;
                ST_E3:   state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (instr_end) begin
                icount    <= icount + 1'b1;
                halt_lat  <= 1'b0;
                step_pend <= 1'b0;
                if (halt_now) begin
                    state    <= ST_IDLE;
                    halted   <= 1'b1;
                    run_flag <= 1'b0;
                end else if (step_pend) begin
                    state <= ST_IDLE;
                end else if (run_now) begin
                    state <= ST_F0;
                end else begin
                    state <= ST_IDLE;
                end
            end
        end
    end

    always_comb begin
        fetch = 1'b0;
        exec  = 1'b0;
        t     = 4'b0000;
        case (state)
            ST_F0:   begin fetch = 1'b1; t = 4'b0001; end
            ST_F1:   begin fetch = 1'b1; t = 4'b0010; end
            ST_F2:   begin fetch = 1'b1; t = 4'b0100; end
            ST_F3:   begin fetch = 1'b1; t = 4'b1000; end
            ST_E0:   begin exec  = 1'b1; t = 4'b0001; end
            ST_E1:   begin exec  = 1'b1; t = 4'b0010; end
            ST_E2:   begin exec  = 1'b1; t = 4'b0100; end
            ST_E3:   begin exec  = 1'b1; t = 4'b1000; end
            default: ;
        endcase
    end

    assign bus.FETCH      = fetch;
    assign bus.EXECUTE    = exec;
    assign bus.T0         = t[0];
    assign bus.T1         = t[1];
    assign bus.T2         = t[2];
    assign bus.T3         = t[3];
    assign bus.INSTR_DONE = instr_done;
    assign bus.HALTED     = halted;
    assign bus.ICOUNT     = icount;
endmodule

// File: tb/tb_dunc16_timing.sv
// Directed bench for dunc16_timing: step vectors from a table, then
// hand-written run, short-exec, halt, wrap and mid-run reset sequences.
module tb_dunc16_timing;
    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    localparam logic [5:0] P_ID = 6'b00_0000;
    localparam logic [5:0] P_F0 = 6'b10_0001, P_F1 = 6'b10_0010, P_F2 = 6'b10_0100, P_F3 = 6'b10_1000;
    localparam logic [5:0] P_E0 = 6'b01_0001, P_E1 = 6'b01_0010, P_E2 = 6'b01_0100, P_E3 = 6'b01_1000;

    typedef struct {
        logic        run, step, halt, sh;
        logic [5:0]  ph;
        logic        done;
        logic [15:0] ic;
    } vec_t;

    logic [5:0] full_seq [8];
    vec_t       tbl [23];
    logic [5:0] q [$];

    dunc16_timing_if bus ();

    dunc16_timing dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [5:0] ph();
        return {bus.FETCH, bus.EXECUTE, bus.T3, bus.T2, bus.T1, bus.T0};
    endfunction

    function automatic vec_t mk(logic r, logic s, logic h, logic x, logic [5:0] p, logic d, logic [15:0] ic);
        vec_t v;
        v.run = r; v.step = s; v.halt = h; v.sh = x; v.ph = p; v.done = d; v.ic = ic;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input string nm, input logic [5:0] p, input logic d, input logic h, input logic [15:0] ic);
        @(negedge CLK);
        chk(nm, {8'h0, ph(), bus.INSTR_DONE, bus.HALTED, bus.ICOUNT}, {8'h0, p, d, h, ic});
    endtask

    task automatic wait_f0(input string nm);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (ph() != P_F0 && n < 10);
        chk(nm, {26'h0, ph()}, {26'h0, P_F0});
    endtask

    initial begin
        full_seq = '{P_F0, P_F1, P_F2, P_F3, P_E0, P_E1, P_E2, P_E3};
        //           run  stp  hlt  sh   phase done ic
        tbl[0]  = mk(0, 1, 0, 0, P_ID, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, P_ID, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, P_F0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 0, P_F1, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, P_F2, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, P_F3, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, P_E0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, P_E1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, P_E2, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, P_E3, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, P_ID, 1, 1);
        tbl[11] = mk(0, 0, 0, 0, P_ID, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, P_ID, 0, 1);
        tbl[13] = mk(0, 1, 0, 0, P_ID, 0, 1);
        tbl[14] = mk(0, 0, 0, 0, P_ID, 0, 1);
        tbl[15] = mk(0, 0, 0, 0, P_F0, 0, 1);
        tbl[16] = mk(0, 0, 0, 0, P_F1, 0, 1);
        tbl[17] = mk(0, 0, 0, 0, P_F2, 0, 1);
        tbl[18] = mk(0, 0, 0, 0, P_F3, 0, 1);
        tbl[19] = mk(0, 0, 0, 1, P_E0, 0, 1);
        tbl[20] = mk(0, 0, 0, 1, P_E1, 0, 1);
        tbl[21] = mk(0, 0, 0, 0, P_ID, 1, 2);
        tbl[22] = mk(0, 0, 0, 0, P_ID, 0, 2);

        RESET = 1'b0;
        bus.RUN = 0; bus.STEP = 0; bus.HALT_REQ = 0; bus.SHORT_EXEC = 0;
        repeat (2) @(negedge CLK);
        chk("reset_state", {8'h0, ph(), bus.INSTR_DONE, bus.HALTED, bus.ICOUNT}, 32'h0);

        // Reset dropped during F2 aborts at once and leaves the sequencer idle.
        RESET = 1'b1;
        @(negedge CLK);
        bus.RUN = 1;
        wait_f0("rst_run_f0");
        cyc("rst_run_f1", P_F1, 0, 0, 0);
        cyc("rst_run_f2", P_F2, 0, 0, 0);
        RESET = 1'b0;
        bus.RUN = 0;
        #1;
        chk("rst_abort", {8'h0, ph(), bus.INSTR_DONE, bus.HALTED, bus.ICOUNT}, 32'h0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        for (int k = 0; k < 4; k++) cyc($sformatf("rst_idle%0d", k), P_ID, 0, 0, 0);

        // Single full step, then single short step.
        for (int i = 0; i < 23; i++) begin
            @(negedge CLK);
            chk($sformatf("tbl%0d", i), {8'h0, ph(), bus.INSTR_DONE, bus.HALTED, bus.ICOUNT},
                {8'h0, tbl[i].ph, tbl[i].done, 1'b0, tbl[i].ic});
            bus.RUN = tbl[i].run; bus.STEP = tbl[i].step;
            bus.HALT_REQ = tbl[i].halt; bus.SHORT_EXEC = tbl[i].sh;
        end

        // Four back-to-back instructions, RUN dropped during the fourth.
        bus.RUN = 1;
        wait_f0("run4_f0");
        for (int k = 1; k < 32; k++) begin
            cyc($sformatf("run4_k%0d", k), full_seq[k % 8], (k % 8) == 0, 0, 16'(2 + k / 8));
            if (k == 24) bus.RUN = 0;
        end
        cyc("run4_end", P_ID, 1, 0, 6);
        cyc("run4_idle0", P_ID, 0, 0, 6);
        cyc("run4_idle1", P_ID, 0, 0, 6);

        // Second instruction short: next F0 follows E1 directly.
        q = {};
        for (int k = 0; k < 8; k++) q.push_back(full_seq[k]);
        for (int k = 0; k < 6; k++) q.push_back(full_seq[k]);
        for (int k = 0; k < 8; k++) q.push_back(full_seq[k]);
        bus.RUN = 1;
        wait_f0("short_f0");
        for (int k = 1; k < 22; k++) begin
            cyc($sformatf("short_k%0d", k), q[k], (k == 8) || (k == 14),
                0, 16'(6 + int'(k >= 8) + int'(k >= 14)));
            if (k == 13) bus.SHORT_EXEC = 1;
            if (k == 14) bus.SHORT_EXEC = 0;
            if (k == 15) bus.RUN = 0;
        end
        cyc("short_end", P_ID, 1, 0, 9);
        cyc("short_idle", P_ID, 0, 0, 9);

        // Halt requested at E2 only; latched, taken at E3, no restart on held RUN.
        bus.RUN = 1;
        wait_f0("halt_f0");
        for (int k = 1; k < 8; k++) begin
            cyc($sformatf("halt_k%0d", k), full_seq[k], 0, 0, 9);
            if (k == 6) bus.HALT_REQ = 1;
            if (k == 7) bus.HALT_REQ = 0;
        end
        cyc("halt_end", P_ID, 1, 1, 10);
        for (int k = 0; k < 5; k++) cyc($sformatf("halt_hold%0d", k), P_ID, 0, 1, 10);
        bus.RUN = 0;
        cyc("halt_runlow", P_ID, 0, 1, 10);
        bus.RUN = 1;
        wait_f0("halt_rerun_f0");
        chk("halt_cleared", {31'h0, bus.HALTED}, 32'h0);
        bus.RUN = 0;
        for (int k = 1; k < 8; k++) cyc($sformatf("rerun_k%0d", k), full_seq[k], 0, 0, 10);
        cyc("rerun_end", P_ID, 1, 0, 11);

        // Counter wrap from 0xFFFF.
        force dut.icount = 16'hFFFF;
        @(negedge CLK);
        release dut.icount;
        cyc("wrap_pre", P_ID, 0, 0, 16'hFFFF);
        bus.STEP = 1;
        cyc("wrap_step", P_ID, 0, 0, 16'hFFFF);
        bus.STEP = 0;
        for (int k = 0; k < 8; k++) cyc($sformatf("wrap_k%0d", k), full_seq[k], 0, 0, 16'hFFFF);
        cyc("wrap_end", P_ID, 1, 0, 16'h0000);
        cyc("wrap_idle", P_ID, 0, 0, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
endmodule
